sel_sequencer: RTL and testbench
================================

Name: sel_sequencer

Overview:
Generates the 2-bit select pair (a, b) that drives the downstream 2-to-4 decoder. It steps the select through 0..3 at a programmable rate, up or down. It runs either free-running or as a single four-step sweep, with start/stop/load control and status pulses. It is the upstream stage feeding decoder inputs a and b; a = sel[1], b = sel[0].

Parameters:
DIV, 4, enabled clock cycles per select step; legal range 1..2^CW.
CW, 8, prescaler counter width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset
en  input  1  prescaler enable; when low, counting freezes but state is held
start  input  1  single-cycle start request
stop  input  1  single-cycle stop request
mode  input  1  0 = continuous run, 1 = single sweep; sampled on accepted start
dir  input  1  0 = up (sel+1), 1 = down (sel-1); sampled on accepted start
load  input  1  load select value
load_val  input  2  value loaded into sel
a  output  1  sel[1], to decoder input a
b  output  1  sel[0], to decoder input b
step  output  1  one-cycle pulse, high in the first cycle a new sel is visible
busy  output  1  high in RUN or SWEEP
done  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: state = IDLE, sel = 0 (a = 0, b = 0), prescaler cnt = 0, step = 0, busy = 0, done = 0, latched dir = 0, sweep count = 0.
- Reset mid-run: on the next edge, everything returns to the reset values; no done pulse.
- States:
  - IDLE: sel held; cnt held at 0.
  - RUN: stepping continuously.
  - SWEEP: stepping, with a 2-bit step count.
- Input priority per cycle: rst > stop > start > load.
- IDLE transitions:
  - start goes to RUN if mode = 0, or SWEEP if mode = 1 (step count cleared). mode and dir are latched on that edge.
  - load without start: sel <= load_val next cycle; step stays 0.
  - load and start together: start wins; load is ignored.
- RUN/SWEEP: load and start are ignored. stop goes to IDLE next cycle, sel keeps its current value, cnt clears, and done stays 0.
- Prescaler: advances only in RUN/SWEEP with en = 1.
  - If cnt == DIV-1: cnt <= 0, sel <= sel ± 1 (mod 4, wrap 3→0 up, 0→3 down), and step <= 1 on the same edge.
  - Otherwise cnt <= cnt+1.
  - With en = 0, cnt and sel are held.
  - DIV = 1 steps on every enabled cycle.
- Latency: start accepted at the edge ending cycle N gives busy = 1 in cycle N+1. With en held high, the first new sel and step appear in cycle N+1+DIV, then every DIV cycles after that.
- SWEEP: the step count increments on each step.
  - On the 4th step: state goes to IDLE and done = 1 on the same edge as that step. So step, done and busy = 0 are all visible in the same cycle.
  - sel is then back at its starting value.
- step and done: pulses only, never high for two consecutive cycles unless DIV = 1. A step on the same edge as stop is suppressed (stop wins).
- Width rules: sel is 2 bits with natural modulo-4 wrap; cnt is CW bits and never exceeds DIV-1.

Decomposition:
- Package sel_seq_pkg:
  - state enum typedef {IDLE, RUN, SWEEP} (2 bits).
  - SEL_W = 2.
  - SWEEP_STEPS = 4.
- Sub-module tick_prescaler (clk, rst, clr, en, tick), parameters DIV and CW. The top-level FSM instantiates it and owns sel, the step count and the status outputs.

Test Plan:
1. Reset, then idle 10 cycles -> a = b = 0, step = busy = done = 0 throughout.
2. DIV = 4, mode = 0, dir = 0, en = 1, start at cycle 0 -> sel 1, 2, 3, 0 in cycles 5, 9, 13, 17 with step pulses there; stop at cycle 20 -> busy = 0 at 21, sel = 0 held.
3. load_val = 2 in IDLE, then sweep with mode = 1, dir = 1, DIV = 4, start at cycle 0 -> sel 1, 0, 3, 2 at cycles 5, 9, 13, 17; done = 1 and busy = 0 at cycle 17 only.
4. en low for 3 cycles mid-run (DIV = 4) -> the next step is delayed by exactly 3 cycles; sel is unchanged while en is low.
5. stop coinciding with a step edge -> sel unchanged, no step, no done, IDLE next cycle; start and load together in IDLE -> start accepted, sel not loaded.
6. rst asserted during SWEEP after 2 steps -> next cycle sel = 0, busy = 0, done never pulses; DIV = 1 run -> sel changes every cycle.

Source files
------------

// File: rtl/sel_seq_pkg.sv
// Shared types and constants for the decoder select sequencer.
package sel_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2
    } state_t;

    localparam int SEL_W       = 2;
    localparam int SWEEP_STEPS = 4;

    function automatic logic [SEL_W-1:0] next_sel(
        input logic [SEL_W-1:0] s,
        input logic             down
    );
        return down ? s - SEL_W'(1) : s + SEL_W'(1);
    endfunction

endpackage

// File: rtl/sel_sequencer_tick_prescaler.sv
// Enabled-cycle divider: tick is high in the cycle that ends a DIV-long period.
module tick_prescaler #(
    parameter int DIV = 4,
    parameter int CW  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sel_sequencer.sv
// Steps the 2-bit decoder select (a, b) up or down at a prescaled rate,
// either free-running or as a single four-step sweep.
import sel_seq_pkg::*;

module sel_sequencer #(
    parameter int DIV = 4,
    parameter int CW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic             a,
    output logic             b,
    output logic             step,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nx;
    logic [SEL_W-1:0] sel, sel_nx;
    logic [1:0]       sweep_cnt, sweep_cnt_nx;
    logic             dir_q, dir_nx;
    logic             step_nx, done_nx;
    logic             active, tick;

    assign active = (state != IDLE);

    // stop clears the prescaler on the same edge, so a coinciding tick is lost
    tick_prescaler #(
        .DIV (DIV),
        .CW  (CW)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (!active || stop),
        .en   (en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            sweep_cnt <= '0;
            dir_q     <= 1'b0;
            step      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            sweep_cnt <= sweep_cnt_nx;
            dir_q     <= dir_nx;
            step      <= step_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        sweep_cnt_nx = sweep_cnt;
        dir_nx       = dir_q;
        step_nx      = 1'b0;
        done_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (start) begin
                    state_nx     = mode ? SWEEP : RUN;
                    dir_nx       = dir;
                    sweep_cnt_nx = '0;
                end else if (load) begin
                    sel_nx = load_val;
                end
            end
            RUN, SWEEP: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (tick) begin
                    sel_nx  = next_sel(sel, dir_q);
                    step_nx = 1'b1;
                    if (state == SWEEP) begin
                        sweep_cnt_nx = sweep_cnt + 2'd1;
                        if (sweep_cnt == 2'(SWEEP_STEPS - 1)) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign a    = sel[1];
    assign b    = sel[0];
    assign busy = active;

endmodule

// File: tb/tb_sel_sequencer.sv
// Bench for sel_sequencer: DIV=4 and DIV=1 instances against a step-count model.
module tb_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [1:0] load_val = 2'd0;

    logic a4, b4, step4, busy4, done4;
    logic a1, b1, step1, busy1, done1;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    int m_busy[2], m_sweep[2], m_dir[2], m_sel[2], m_ssel[2];
    int m_e[2], m_step[2], m_done[2];
    int k;

    always #5 clk = ~clk;

    sel_sequencer #(.DIV(4), .CW(8)) dut4 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .mode(mode), .dir(dir), .load(load), .load_val(load_val),
        .a(a4), .b(b4), .step(step4), .busy(busy4), .done(done4)
    );

    sel_sequencer #(.DIV(1), .CW(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .mode(mode), .dir(dir), .load(load), .load_val(load_val),
        .a(a1), .b(b1), .step(step1), .busy(busy1), .done(done1)
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // sel = start value +/- (number of completed DIV-long enabled periods)
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 0;
            m_done[i] = 0;
            if (rst) begin
                m_busy[i] = 0; m_sweep[i] = 0; m_dir[i] = 0;
                m_sel[i] = 0; m_ssel[i] = 0; m_e[i] = 0;
            end else if (m_busy[i] != 0) begin
                if (stop) begin
                    m_busy[i] = 0;
                end else if (en) begin
                    m_e[i] = m_e[i] + 1;
                    if (m_e[i] % div_of(i) == 0) begin
                        k = m_e[i] / div_of(i);
                        m_sel[i] = (m_ssel[i] + (m_dir[i] != 0 ? 3 * k : k)) % 4;
                        m_step[i] = 1;
                        if (m_sweep[i] != 0 && k == 4) begin
                            m_busy[i] = 0;
                            m_done[i] = 1;
                        end
                    end
                end
            end else if (!stop) begin
                if (start) begin
                    m_busy[i] = 1; m_sweep[i] = int'(mode);
                    m_dir[i] = int'(dir); m_ssel[i] = m_sel[i]; m_e[i] = 0;
                end else if (load) begin
                    m_sel[i] = int'(load_val);
                end
            end
        end
    end

    function automatic int exp_vec(input int i);
        return m_sel[i] * 8 + m_step[i] * 4 + m_busy[i] * 2 + m_done[i];
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_div4", int'({a4, b4, step4, busy4, done4}), exp_vec(0));
            chk("model_div1", int'({a1, b1, step1, busy1, done1}), exp_vec(1));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic int sel4();
        return int'({a4, b4});
    endfunction

    function automatic int sel1();
        return int'({a1, b1});
    endfunction

    initial begin
        cyc(); cyc();
        rst = 1'b0;
        cmp_on = 1'b1;

        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("idle_outputs", int'({a4, b4, step4, busy4, done4}), 0);
        end

        en = 1'b1; start = 1'b1; mode = 1'b0; dir = 1'b0;
        cyc(); start = 1'b0;
        chk("div1_busy", int'(busy1), 1);
        chk("div1_sel_c1", sel1(), 0);
        cyc(); chk("div1_sel_c2", sel1(), 1);
        cyc(); chk("div1_sel_c3", sel1(), 2);
        chk("div1_step_c3", int'(step1), 1);
        stop = 1'b1; cyc(); stop = 1'b0;

        start = 1'b1; cyc(); start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            if (c == 5)  begin chk("run_sel_c5", sel4(), 1); chk("run_step_c5", int'(step4), 1); end
            if (c == 6)  chk("run_step_c6", int'(step4), 0);
            if (c == 9)  chk("run_sel_c9", sel4(), 2);
            if (c == 13) chk("run_sel_c13", sel4(), 3);
            if (c == 17) begin chk("run_sel_c17", sel4(), 0); chk("run_step_c17", int'(step4), 1); end
            if (c == 20) chk("run_busy_c20", int'(busy4), 1);
            if (c == 21) begin
                chk("stop_busy", int'(busy4), 0);
                chk("stop_sel", sel4(), 0);
                chk("stop_nostep", int'(step4), 0);
                chk("stop_nodone", int'(done4), 0);
            end
            stop = (c == 20);
            cyc();
        end
        stop = 1'b0;

        load_val = 2'd2; load = 1'b1; cyc(); load = 1'b0;
        chk("load_sel", sel4(), 2);
        chk("load_nostep", int'(step4), 0);

        mode = 1'b1; dir = 1'b1; start = 1'b1; cyc(); start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 5)  chk("sweep_sel_c5", sel4(), 1);
            if (c == 9)  chk("sweep_sel_c9", sel4(), 0);
            if (c == 13) chk("sweep_sel_c13", sel4(), 3);
            if (c == 16) chk("sweep_state_c16", int'({busy4, done4}), 2);
            if (c == 17) begin
                chk("sweep_sel_c17", sel4(), 2);
                chk("sweep_end_c17", int'({step4, busy4, done4}), 5);
            end
            if (c == 18) chk("sweep_c18", int'({step4, busy4, done4}), 0);
            cyc();
        end

        mode = 1'b0; dir = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c >= 5 && c <= 7) chk("en_hold_sel", sel4(), 2);
            if (c == 8) chk("en_delay_c8", int'({a4, b4, step4}), 7);
            if (c == 9) chk("en_stop_busy", int'(busy4), 0);
            en = !(c >= 2 && c <= 4);
            stop = (c == 8);
            cyc();
        end
        en = 1'b1; stop = 1'b0;

        load_val = 2'd1; load = 1'b1; start = 1'b1;
        cyc(); load = 1'b0; start = 1'b0;
        chk("start_load_busy", int'(busy4), 1);
        chk("start_load_sel", sel4(), 3);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("start_load_stop", int'(busy4), 0);

        mode = 1'b1; dir = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) chk("rst_sweep_c5", sel4(), 0);
            if (c == 9) chk("rst_sweep_c9", sel4(), 1);
            rst = (c == 10);
            cyc();
        end
        chk("rst_mid_sweep", int'({a4, b4, step4, busy4, done4}), 0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk("post_rst_quiet", int'({busy4, done4}), 0);
        end

        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 9) < 8);
            start    = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 2'($urandom_range(0, 3));
            mode     = 1'($urandom_range(0, 1));
            dir      = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
